// File: rtl/state_mon_pkg.sv
// Shared types and widths for the FSM state dwell monitor.
package state_mon_pkg;

    localparam int unsigned StateW = 2;
    localparam int unsigned CntW   = 16;
    localparam int unsigned EvtW   = 2 * StateW + CntW;

    typedef enum logic [StateW-1:0] {
        STATE0 = 2'd0,
        STATE1 = 2'd1,
        STATE2 = 2'd2,
        STATE3 = 2'd3
    } state_t;

    // Transition record as it appears on evt_data, MSB first.
    typedef struct packed {
        state_t            from_state;
        state_t            to_state;
        logic [CntW-1:0]   dwell;
    } state_evt_t;

endpackage

// File: rtl/state_dwell_monitor_if.sv
// Valid/ready stream carrying transition records out of the monitor.
interface state_dwell_monitor_if
    import state_mon_pkg::*;
#(
    parameter int unsigned DATA_W = EvtW
) ();

    logic              evt_valid;
    logic              evt_ready;
    logic [DATA_W-1:0] evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);

endinterface

// File: rtl/state_evt_fifo.sv
// Synchronous first-word-fall-through FIFO; head data reads as zero when empty.
module state_evt_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(DEPTH);

    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCnt);
    // When full, a push is still accepted if the head leaves on the same edge.
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign full_o  = full;
    assign count_o = count_q;

endmodule

// File: rtl/state_dwell_monitor.sv
// Measures how long an FSM holds each state and logs every transition to a FIFO,
// with an overstay pulse and sticky/counting record-loss status.
module state_dwell_monitor
    import state_mon_pkg::*;
#(
    parameter int unsigned STATE_W = StateW,
    parameter int unsigned CNT_W   = CntW,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_i,
    input  logic                 clear_i,
    input  logic [STATE_W-1:0]   state_i,
    state_dwell_monitor_if.master evt,
    output logic                 timeout_o,
    output logic                 overflow_o,
    output logic [7:0]           drop_cnt_o
);

    localparam int unsigned DataW = 2 * STATE_W + CNT_W;
    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

    logic               primed_q, primed_d;
    logic [STATE_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic               timeout_q, timeout_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic               push_req, restart, pop;
    logic               fifo_full, fifo_valid;
    logic [AddrW:0]     fifo_count;
    logic [DataW-1:0]   fifo_rdata;

    assign fifo_valid = (fifo_count != '0);
    assign pop        = fifo_valid && evt.evt_ready;

    always_comb begin
        primed_d   = primed_q;
        prev_d     = prev_q;
        dwell_d    = dwell_q;
        timeout_d  = 1'b0;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        push_req   = 1'b0;
        restart    = 1'b0;
        if (clear_i) begin
            primed_d   = 1'b0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (en_i) begin
            if (!primed_q) begin
                primed_d = 1'b1;
                prev_d   = state_i;
                dwell_d  = CNT_W'(1);
                restart  = 1'b1;
            end else if (state_i != prev_q) begin
                push_req = 1'b1;
                prev_d   = state_i;
                dwell_d  = CNT_W'(1);
                restart  = 1'b1;
            end else if (dwell_q != CntMax) begin
                dwell_d = dwell_q + 1'b1;
            end
            // Fire only on the edge that reaches TIMEOUT, never while parked there.
            timeout_d = (dwell_d == TimeoutVal) && (restart || (dwell_d != dwell_q));
            if (push_req && fifo_full && !pop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hff) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            primed_q   <= 1'b0;
            prev_q     <= '0;
            dwell_q    <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            primed_q   <= primed_d;
            prev_q     <= prev_d;
            dwell_q    <= dwell_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    state_evt_fifo #(
        .WIDTH (DataW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear_i),
        .push_i  (push_req),
        .data_i  ({prev_q, state_i, dwell_q}),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign evt.evt_valid = fifo_valid;
    assign evt.evt_data  = fifo_rdata;
    assign timeout_o     = timeout_q;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_state_dwell_monitor.sv
// Self-checking bench for state_dwell_monitor: table-driven transitions plus
// hand-written timeout, overflow, clear, enable-freeze and reset sequences.
module tb_state_dwell_monitor;
    import state_mon_pkg::*;

    typedef logic [EvtW-1:0] rec_t;

    typedef struct {
        logic [1:0]  st;
        int unsigned hold;
        logic        exp_evt;
        logic [1:0]  from_st;
        int unsigned dwell;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_i;
    logic       clear_i;
    logic [1:0] state_i;
    logic       timeout_o;
    logic       overflow_o;
    logic [7:0] drop_cnt_o;

    state_dwell_monitor_if evt_bus ();

    state_dwell_monitor #(
        .STATE_W (2),
        .CNT_W   (16),
        .DEPTH   (8),
        .TIMEOUT (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en_i       (en_i),
        .clear_i    (clear_i),
        .state_i    (state_i),
        .evt        (evt_bus),
        .timeout_o  (timeout_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   to_cnt = 0;
    int   to_cyc = 0;
    rec_t exp_q[$];
    vec_t tbl[6];

    function automatic rec_t rec(input logic [1:0] f, input logic [1:0] t, input int unsigned d);
        state_evt_t e;
        e.from_state = state_t'(f);
        e.to_state   = state_t'(t);
        e.dwell      = d[15:0];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sample between edges: score handshakes and timeout pulses, then advance one cycle.
    task automatic tick();
        rec_t exp;
        @(negedge clk);
        cyc++;
        if (timeout_o === 1'b1) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (evt_bus.evt_valid === 1'b1 && evt_bus.evt_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_record: got %0h expected none", evt_bus.evt_data);
            end else begin
                exp = exp_q.pop_front();
                if (evt_bus.evt_data !== exp) begin
                    errors++;
                    $display("FAIL record_data: got %0h expected %0h", evt_bus.evt_data, exp);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(evt_bus.evt_valid), 32'd0);
        chk({tag, "_data"}, 32'(evt_bus.evt_data), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout_o), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow_o), 32'd0);
        chk({tag, "_drop"}, 32'(drop_cnt_o), 32'd0);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        en_i    = 1'b0;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        logic [1:0] prv;
        logic [1:0] nxt;
        int         base;
        int         to0;

        tbl[0] = '{2'd0, 5, 1'b0, 2'd0, 0};
        tbl[1] = '{2'd3, 2, 1'b1, 2'd0, 5};
        tbl[2] = '{2'd0, 4, 1'b1, 2'd3, 2};
        tbl[3] = '{2'd3, 3, 1'b1, 2'd0, 4};
        tbl[4] = '{2'd1, 1, 1'b1, 2'd3, 3};
        tbl[5] = '{2'd2, 2, 1'b1, 2'd1, 1};

        reset = 1'b1;
        en_i = 1'b0;
        clear_i = 1'b0;
        state_i = 2'd0;
        evt_bus.evt_ready = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        reset = 1'b0;

        // Table-driven transitions with the consumer always ready.
        evt_bus.evt_ready = 1'b1;
        en_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            state_i = tbl[i].st;
            if (tbl[i].exp_evt) begin
                exp_q.push_back(rec(tbl[i].from_st, tbl[i].st, tbl[i].dwell));
            end
            tick();
            chk($sformatf("row%0d_latency", i), 32'(evt_bus.evt_valid), 32'(tbl[i].exp_evt));
            for (int h = 1; h < int'(tbl[i].hold); h++) begin
                tick();
                if (h == 1) begin
                    chk($sformatf("row%0d_one_cycle", i), 32'(evt_bus.evt_valid), 32'd0);
                end
            end
        end
        en_i = 1'b0;
        repeat (3) tick();
        chk("table_drained", 32'(exp_q.size()), 32'd0);
        chk("table_no_timeout", 32'(to_cnt), 32'd0);

        // Timeout: entry edge is in tick 1, dwell hits 10 on tick 10's edge, seen in tick 11.
        do_clear();
        en_i = 1'b1;
        state_i = 2'd2;
        base = cyc;
        to0 = to_cnt;
        repeat (25) tick();
        chk("timeout1_count", 32'(to_cnt - to0), 32'd1);
        chk("timeout1_when", 32'(to_cyc - base), 32'd11);
        state_i = 2'd1;
        exp_q.push_back(rec(2'd2, 2'd1, 25));
        base = cyc;
        to0 = to_cnt;
        repeat (12) tick();
        chk("timeout2_count", 32'(to_cnt - to0), 32'd1);
        chk("timeout2_when", 32'(to_cyc - base), 32'd11);
        chk("timeout_rec_drained", 32'(exp_q.size()), 32'd0);

        // Overflow: 10 transitions into an 8-deep FIFO with no consumer.
        do_clear();
        evt_bus.evt_ready = 1'b0;
        en_i = 1'b1;
        state_i = 2'd0;
        tick();
        prv = 2'd0;
        for (int i = 0; i < 10; i++) begin
            nxt = prv + 2'd1;
            state_i = nxt;
            if (i < 8) exp_q.push_back(rec(prv, nxt, 1));
            tick();
            prv = nxt;
        end
        en_i = 1'b0;
        tick();
        chk("ovf_flag", 32'(overflow_o), 32'd1);
        chk("ovf_drop_cnt", 32'(drop_cnt_o), 32'd2);
        chk("ovf_valid", 32'(evt_bus.evt_valid), 32'd1);
        chk("ovf_head_hold", 32'(evt_bus.evt_data), 32'(exp_q[0]));

        // Full FIFO: push coincident with pop is accepted without a drop.
        en_i = 1'b1;
        evt_bus.evt_ready = 1'b1;
        state_i = 2'd3;
        exp_q.push_back(rec(2'd2, 2'd3, 1));
        tick();
        en_i = 1'b0;
        evt_bus.evt_ready = 1'b0;
        tick();
        chk("full_pushpop_drop", 32'(drop_cnt_o), 32'd2);
        evt_bus.evt_ready = 1'b1;
        repeat (10) tick();
        chk("full_drained", 32'(exp_q.size()), 32'd0);
        chk("full_drain_valid", 32'(evt_bus.evt_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);

        // Clear with a record pending, then re-prime without an event.
        evt_bus.evt_ready = 1'b0;
        en_i = 1'b1;
        state_i = 2'd0;
        tick();
        en_i = 1'b0;
        chk("pre_clear_valid", 32'(evt_bus.evt_valid), 32'd1);
        do_clear();
        check_reset_vals("clear");
        evt_bus.evt_ready = 1'b1;
        en_i = 1'b1;
        state_i = 2'd1;
        tick();
        chk("reprime_no_evt", 32'(evt_bus.evt_valid), 32'd0);
        tick();
        state_i = 2'd2;
        exp_q.push_back(rec(2'd1, 2'd2, 2));
        tick();
        chk("reprime_evt", 32'(evt_bus.evt_valid), 32'd1);
        tick();

        // Enable low freezes the dwell count while state wanders and returns.
        do_clear();
        en_i = 1'b1;
        state_i = 2'd1;
        repeat (3) tick();
        en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            state_i = 2'(i + 2);
            tick();
            chk($sformatf("frozen%0d_valid", i), 32'(evt_bus.evt_valid), 32'd0);
        end
        en_i = 1'b1;
        repeat (2) tick();
        state_i = 2'd2;
        exp_q.push_back(rec(2'd1, 2'd2, 5));
        tick();
        chk("resume_evt", 32'(evt_bus.evt_valid), 32'd1);
        tick();
        chk("resume_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-dwell with a record pending.
        evt_bus.evt_ready = 1'b0;
        state_i = 2'd3;
        tick();
        chk("pre_reset_valid", 32'(evt_bus.evt_valid), 32'd1);
        reset = 1'b1;
        tick();
        check_reset_vals("midreset");
        reset = 1'b0;
        state_i = 2'd0;
        tick();
        chk("post_reset_prime", 32'(evt_bus.evt_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/state_dwell_monitor.md
Name: state_dwell_monitor

Overview:
- Downstream observer of the 2-bit control FSM state register (STATE0..STATE3).
- Samples the FSM state every enabled cycle and measures how long each state is held (dwell).
- Logs every state transition as a record into a small FIFO, drained over a valid/ready interface.
- Flags overstays (timeout) and lost records (overflow) for debug/status logic.

Parameters:
- STATE_W, 2, width of the observed state.
- CNT_W, 16, dwell counter width (saturating).
- DEPTH, 8, event FIFO depth; power of two, >= 2.
- TIMEOUT, 1000, dwell cycle count that raises timeout_o; 1 <= TIMEOUT <= 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- en_i  in  1  sample enable; low freezes all monitoring.
- clear_i  in  1  synchronous flush of FIFO and status; re-primes the monitor.
- state_i  in  STATE_W  observed FSM current_state.
- evt_valid_o  out  1  FIFO head valid.
- evt_ready_i  in  1  consumer accepts head.
- evt_data_o  out  2*STATE_W+CNT_W  {from_state, to_state, dwell}, MSB first.
- timeout_o  out  1  one-cycle pulse when dwell reaches TIMEOUT.
- overflow_o  out  1  sticky: a record was dropped.
- drop_cnt_o  out  8  saturating count of dropped records.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk. Reset has priority over clear_i, and clear_i has priority over en_i.
- Reset values: evt_valid_o=0, evt_data_o=0, timeout_o=0, overflow_o=0, drop_cnt_o=0. FIFO is empty, primed=0, dwell_q=0, prev_q=0.
- Priming: the first enabled cycle after reset or clear latches prev_q<=state_i and dwell_q<=1 and sets primed. No event is generated on that cycle.
- Primed, en_i=1, state_i==prev_q: dwell_q<=dwell_q+1, saturating at 2^CNT_W-1.
- Primed, en_i=1, state_i!=prev_q:
  - Push the record {prev_q, state_i, dwell_q}.
  - prev_q<=state_i; dwell_q<=1.
- en_i=0: prev_q and dwell_q hold. No push. Timeout is not evaluated. FIFO pop still operates.
- Timeout: timeout_o=1 for exactly the one cycle after the edge where dwell_q becomes TIMEOUT. It fires at most once per dwell period, and is not re-raised while saturated. A state change resets the condition.
- FIFO timing:
  - First-word fall-through. A push at edge N makes evt_valid_o=1 and evt_data_o the record from cycle N+1 on, if the FIFO was empty.
  - Pop when evt_valid_o and evt_ready_i are both high at an edge.
  - evt_data_o holds while valid and not ready.
- FIFO full:
  - Push with a simultaneous pop is accepted; occupancy is unchanged.
  - Push without a pop drops the new record. overflow_o<=1, and drop_cnt_o increments, saturating at 255.
- Empty with simultaneous push and pop: the pop is ignored because valid was low. The push lands.
- clear_i: FIFO empty, evt_valid_o=0, overflow_o=0, drop_cnt_o=0, primed=0, timeout_o=0, all in one cycle. A change coincident with clear_i is not logged.
- Pointers are log2(DEPTH) bits wide with wrap-around, plus an occupancy counter of log2(DEPTH)+1 bits.
- Latency from state change at the input to evt_valid_o: 1 cycle (FIFO empty).

Decomposition:
- Package state_mon_pkg:
  - state_t enum (STATE0..STATE3).
  - state_evt_t packed struct {from, to, dwell}.
  - Width localparams.
- Sub-module state_evt_fifo: parameterised sync FWFT FIFO with push/pop/full/empty/count. The top handles the dwell logic, the drop policy and status.

Test Plan:
- Reset then en_i=1 with state held at STATE0 for 5 cycles, then STATE3 -> one record {0,3,5}; evt_valid_o rises 1 cycle after the change; no record on the priming cycle.
- Sequence 0->3 (hold 2)->0 (hold 4)->3 with evt_ready_i=1 -> records {0,3,·}, {3,0,2}, {0,3,4} in order, each valid for one cycle.
- TIMEOUT=10, hold STATE2 for 25 cycles -> a single timeout_o pulse 10 cycles after entry; change to STATE1 then hold 10 -> a second pulse.
- DEPTH=8, evt_ready_i=0, 10 transitions -> 8 records held, overflow_o=1, drop_cnt_o=2. Drain -> the first 8 records arrive in order.
- FIFO full, push coincident with pop -> occupancy stays 8, drop_cnt_o unchanged. Then clear_i -> evt_valid_o=0, overflow_o=0, drop_cnt_o=0, and the next enabled cycle re-primes with no event.
- en_i low for 4 cycles mid-dwell while state_i changes and returns -> no record; dwell resumes from the held value. Assert reset mid-dwell -> all outputs return to reset values next cycle.
